// File: rtl/tinker_control_fsm_if.sv
// Handshake and strobe bundle between the Tinker sequencer and its datapath/memories/FPU.
// master = sequencer side, slave = datapath side.
interface tinker_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       opcode;
   logic             lit_zero;
   logic             branch_taken;
   logic             imem_req;
   logic             imem_ack;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   logic             fpu_start;
   logic             fpu_done;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             rf_we;
   logic             hlt;
   logic             err;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, lit_zero, branch_taken, imem_ack, dmem_ack, fpu_done,
      output imem_req, dmem_req, dmem_we, fpu_start, ir_we, pc_we, pc_sel,
             rf_we, hlt, err, retired
   );

   modport slave (
      output opcode, lit_zero, branch_taken, imem_ack, dmem_ack, fpu_done,
      input  imem_req, dmem_req, dmem_we, fpu_start, ir_we, pc_we, pc_sel,
             rf_we, hlt, err, retired
   );
endinterface

// File: rtl/tinker_control_fsm.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the Tinker core.
// state  | meaning
// FETCH  | imem_req held, waiting for imem_ack (timed)
// DECODE | one cycle, classify opcode
// EXEC   | ALU pass, branch retire, FPU wait (timed), or hand off to MEM
// MEM    | dmem_req held, waiting for dmem_ack (timed)
// WB     | register write, PC+4, retire
// HALT   | sticky halt, only reset leaves
// FAULT  | sticky error (timeout or illegal opcode), only reset leaves
module tinker_control_fsm #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 32
) (
   input logic                  clk,
   input logic                  reset,
   tinker_control_fsm_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   localparam int WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_LIMIT - 1);

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wcnt, wcnt_nxt;
   logic [CNT_W-1:0]  retired_q;
   logic              imem_req_c, dmem_req_c, dmem_we_c, fpu_start_c;
   logic              ir_we_c, pc_we_c, rf_we_c;
   logic [1:0]        pc_sel_c;
   logic              is_memrd, is_memwr, is_br, is_halt, is_fpu, is_ill;
   logic              wait_last;

   assign is_memrd  = (bus.opcode == 5'h10) || (bus.opcode == 5'h0d);
   assign is_memwr  = (bus.opcode == 5'h13) || (bus.opcode == 5'h0c);
   assign is_br     = (bus.opcode inside {[5'h08:5'h0b], 5'h0e});
   assign is_halt   = (bus.opcode == 5'h0f) && bus.lit_zero;
   assign is_fpu    = (bus.opcode inside {[5'h14:5'h17]});
   assign is_ill    = (bus.opcode inside {5'h1e, 5'h1f});
   // Last allowed wait cycle: an ack here still wins, its absence faults.
   assign wait_last = (wcnt == WCNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         wcnt      <= '0;
         retired_q <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (pc_we_c) retired_q <= retired_q + 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      wcnt_nxt    = wcnt;
      imem_req_c  = 1'b0;
      dmem_req_c  = 1'b0;
      dmem_we_c   = 1'b0;
      fpu_start_c = 1'b0;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      pc_sel_c    = 2'b00;
      rf_we_c     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ack) begin
               ir_we_c   = 1'b1;
               state_nxt = S_DECODE;
            end else if (wait_last) begin
               state_nxt = S_FAULT;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         S_DECODE: begin
            wcnt_nxt = '0;
            if (is_halt)     state_nxt = S_HALT;
            else if (is_ill) state_nxt = S_FAULT;
            else             state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (is_fpu) begin
               // wcnt is zero only in the first EXEC cycle of an FPU op
               fpu_start_c = (wcnt == '0);
               if (bus.fpu_done)   state_nxt = S_WB;
               else if (wait_last) state_nxt = S_FAULT;
               else                wcnt_nxt  = wcnt + 1'b1;
            end else if (is_br) begin
               pc_we_c   = 1'b1;
               pc_sel_c  = bus.branch_taken ? 2'b01 : 2'b00;
               wcnt_nxt  = '0;
               state_nxt = S_FETCH;
            end else if (is_memrd || is_memwr) begin
               wcnt_nxt  = '0;
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = is_memwr;
            if (bus.dmem_ack) begin
               if (bus.opcode == 5'h10) begin
                  state_nxt = S_WB;
               end else begin
                  pc_we_c   = 1'b1;
                  pc_sel_c  = (bus.opcode == 5'h0d) ? 2'b10 :
                              (bus.opcode == 5'h0c) ? 2'b01 : 2'b00;
                  wcnt_nxt  = '0;
                  state_nxt = S_FETCH;
               end
            end else if (wait_last) begin
               state_nxt = S_FAULT;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         S_WB: begin
            rf_we_c   = 1'b1;
            pc_we_c   = 1'b1;
            wcnt_nxt  = '0;
            state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_FAULT;
      endcase
   end

   // Requests and strobes drop in the very cycle reset is asserted.
   assign bus.imem_req  = imem_req_c  & ~reset;
   assign bus.dmem_req  = dmem_req_c  & ~reset;
   assign bus.dmem_we   = dmem_we_c   & ~reset;
   assign bus.fpu_start = fpu_start_c & ~reset;
   assign bus.ir_we     = ir_we_c     & ~reset;
   assign bus.pc_we     = pc_we_c     & ~reset;
   assign bus.rf_we     = rf_we_c     & ~reset;
   assign bus.pc_sel    = (pc_we_c & ~reset) ? pc_sel_c : 2'b00;
   assign bus.hlt       = (state == S_HALT);
   assign bus.err       = (state == S_FAULT);
   assign bus.retired   = retired_q;

endmodule
